// File: rtl/kogge_stone_adder_pkg.sv
// Shared types and helpers for the Kogge-Stone adder.
package ksa_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Prefix depth for a given operand width; usable in constant expressions.
  function automatic int clog2(input int n);
    int levels;
    int span;
    levels = 0;
    span   = 1;
    while (span < n) begin
      span   = span << 1;
      levels = levels + 1;
    end
    return levels;
  endfunction

endpackage

// File: rtl/kogge_stone_adder_if.sv
// Operand/result bundle for the Kogge-Stone adder.
interface kogge_stone_adder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output a, b, cin, input sum, cout);
  modport slave  (input a, b, cin, output sum, cout);
endinterface

// File: rtl/kogge_stone_adder_gp_cell.sv
// Black prefix cell: merges a high group (g,p) with the adjacent low group.
// A gray cell is this cell with the p output left unused.
module ksa_gp_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);
  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;
endmodule

// File: rtl/kogge_stone_adder.sv
// Registered WIDTH-bit Kogge-Stone adder: {cout,sum} = a + b + cin, 1-cycle latency.
// Optional macro KSA_IN_REG_EN adds an input register stage (2-cycle latency).
module kogge_stone_adder
  import ksa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                clk,
  input logic                rst,
  kogge_stone_adder_if.slave bus
);
  localparam int LEVELS = clog2(WIDTH);

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;

`ifdef KSA_IN_REG_EN
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic             cin_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      cin_reg <= 1'b0;
    end else begin
      a_reg   <= bus.a;
      b_reg   <= bus.b;
      cin_reg <= bus.cin;
    end
  end

  assign op_a   = a_reg;
  assign op_b   = b_reg;
  assign op_cin = cin_reg;
`else
  assign op_a   = bus.a;
  assign op_b   = bus.b;
  assign op_cin = bus.cin;
`endif

  gp_t [WIDTH-1:0] gp_bit;
  gp_t [WIDTH-1:0] gp_final;
  logic [WIDTH:0]  carry;
  logic [WIDTH-1:0] sum_next;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  genvar gi, gj;

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pre
      assign gp_bit[gi].g = op_a[gi] & op_b[gi];
      assign gp_bit[gi].p = op_a[gi] ^ op_b[gi];
    end

    for (gi = 0; gi < LEVELS; gi++) begin : g_level
      localparam int DIST = 1 << gi;
      gp_t [WIDTH-1:0] gp_src;
      gp_t [WIDTH-1:0] gp_dst;

      if (gi == 0) begin : g_first
        assign gp_src = gp_bit;
      end else begin : g_chain
        assign gp_src = g_level[gi-1].gp_dst;
      end

      for (gj = 0; gj < WIDTH; gj++) begin : g_col
        if (gj >= DIST) begin : g_cell
          ksa_gp_cell u_cell (
            .g_hi (gp_src[gj].g),
            .p_hi (gp_src[gj].p),
            .g_lo (gp_src[gj-DIST].g),
            .p_lo (gp_src[gj-DIST].p),
            .g    (gp_dst[gj].g),
            .p    (gp_dst[gj].p)
          );
        end else begin : g_pass
          assign gp_dst[gj] = gp_src[gj];
        end
      end
    end

    assign gp_final = g_level[LEVELS-1].gp_dst;

    // cin enters as the generate of bit -1: each prefix group absorbs it via its P term.
    assign carry[0] = op_cin;
    for (gi = 0; gi < WIDTH; gi++) begin : g_carry
      assign carry[gi+1]  = gp_final[gi].g | (gp_final[gi].p & op_cin);
      assign sum_next[gi] = gp_bit[gi].p ^ carry[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_reg  <= '0;
      cout_reg <= 1'b0;
    end else begin
      sum_reg  <= sum_next;
      cout_reg <= carry[WIDTH];
    end
  end

  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;

endmodule

// File: tb/tb_kogge_stone_adder.sv
// Self-checking bench: 16-bit and 13-bit adders driven in lock-step against a+b+cin scoreboards.
module tb_kogge_stone_adder;

`ifdef KSA_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kogge_stone_adder_if #(.WIDTH(16)) bus16 ();
  kogge_stone_adder_if #(.WIDTH(13)) bus13 ();

  kogge_stone_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  kogge_stone_adder #(.WIDTH(13)) dut13 (.clk(clk), .rst(rst), .bus(bus13.slave));

  int compared   = 0;
  int mismatched = 0;

  logic [16:0] q16[$];
  logic [13:0] q13[$];

  task automatic cmp16(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s w16: got {cout,sum}=%h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cmp13(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s w13: got {cout,sum}=%h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive, optionally push expectation, clock, then check whatever is due.
  task automatic step(input string tag, input logic r, input logic [15:0] av,
                      input logic [15:0] bv, input logic c, input bit push, input bit verbose);
    logic [12:0] a13;
    logic [12:0] b13;
    a13 = av[12:0];
    b13 = bv[12:0];
    rst = r;
    bus16.a = av;  bus16.b = bv;  bus16.cin = c;
    bus13.a = a13; bus13.b = b13; bus13.cin = c;
    if (push && !r) begin
      q16.push_back({1'b0, av} + {1'b0, bv} + 17'(c));
      q13.push_back({1'b0, a13} + {1'b0, b13} + 14'(c));
    end
    @(posedge clk);
    #1;
    if (r) begin
      cmp16(tag, {bus16.cout, bus16.sum}, 17'h0);
      cmp13(tag, {bus13.cout, bus13.sum}, 14'h0);
      q16.delete();
      q13.delete();
      // cleared input registers will present 0+0+0 on the first edge out of reset
      if (LAT == 2) begin
        q16.push_back(17'h0);
        q13.push_back(14'h0);
      end
    end else begin
      if (q16.size() >= (push ? LAT : 1)) cmp16(tag, {bus16.cout, bus16.sum}, q16.pop_front());
      if (q13.size() >= (push ? LAT : 1)) cmp13(tag, {bus13.cout, bus13.sum}, q13.pop_front());
    end
    if (verbose)
      $display("%s: rst=%0d a=%h b=%h cin=%0d -> w16 sum=%h cout=%0d | w13 sum=%h cout=%0d",
               tag, r, av, bv, c, bus16.sum, bus16.cout, bus13.sum, bus13.cout);
  endtask

  initial begin
    bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0;
    bus13.a = '0; bus13.b = '0; bus13.cin = 1'b0;

    step("reset0", 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1);
    step("reset1", 1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1);
    step("release", 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1);
    step("hold_ones", 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1);

    step("v158a_c0", 1'b0, 16'h158A, 16'h7095, 1'b0, 1'b1, 1'b1);
    step("v158a_c1", 1'b0, 16'h158A, 16'h7095, 1'b1, 1'b1, 1'b1);
    step("v52af_9a4e", 1'b0, 16'h52AF, 16'h9A4E, 1'b0, 1'b1, 1'b1);
    step("v52af_c6bd", 1'b0, 16'h52AF, 16'hC6BD, 1'b0, 1'b1, 1'b1);
    step("vb903_c0", 1'b0, 16'hB903, 16'hC6BD, 1'b0, 1'b1, 1'b1);
    step("vb903_c1", 1'b0, 16'hB903, 16'hC6BD, 1'b1, 1'b1, 1'b1);
    step("full_prop", 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 1'b1);
    step("msb_carry", 1'b0, 16'h8000, 16'h8000, 1'b0, 1'b1, 1'b1);
    step("zeros", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
    step("prop_1fff", 1'b0, 16'h1FFF, 16'h0000, 1'b1, 1'b1, 1'b1);
    step("ones_noc", 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 10000; i++) begin
      step("random", 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, 1'b0);
    end

    for (int i = 0; i < LAT; i++) begin
      step("drain", 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    end

    // a re-entry into reset mid-stream must clear the outputs again
    step("reset_again", 1'b1, 16'hA5A5, 16'h5A5A, 1'b1, 1'b1, 1'b1);
    step("after_reset", 1'b0, 16'h1234, 16'h4321, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < LAT; i++) begin
      step("drain2", 1'b0, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
